// File: rtl/pc_gen_pkg.sv
// Shared types and constants for the rooth fetch PC generator.
// Build switch: define ROOTH_RVC_EN for compressed-instruction support (+2 step, halfword-aligned redirects).
package pc_gen_pkg;

   localparam int FLOW_WIDTH = 2;

   localparam logic [FLOW_WIDTH-1:0] FLOW_WORK    = 2'd0;
   localparam logic [FLOW_WIDTH-1:0] FLOW_STOP    = 2'd1;
   localparam logic [FLOW_WIDTH-1:0] FLOW_REFRESH = 2'd2;

   typedef enum logic [1:0] {
      PCG_BOOT = 2'd0,
      PCG_RUN  = 2'd1,
      PCG_HALT = 2'd2
   } pcg_state_e;

   // Any code that is neither WORK nor STOP restarts fetch from the reset vector.
   function automatic logic flow_is_refresh(input logic [FLOW_WIDTH-1:0] flow);
      return (flow != FLOW_WORK) && (flow != FLOW_STOP);
   endfunction

endpackage

// File: rtl/pc_redir_arb.sv
// Fixed-priority redirect arbiter: channel 0 wins, target is aligned before use.
// Build switch: ROOTH_RVC_EN clears only bit 0 of the target, otherwise bits [1:0].
module pc_redir_arb #(
   parameter int XLEN      = 32,
   parameter int NUM_REDIR = 3
) (
   input  logic [NUM_REDIR-1:0]      redir_valid_i,
   input  logic [NUM_REDIR*XLEN-1:0] redir_pc_i,
   output logic [NUM_REDIR-1:0]      grant_o,
   output logic                      any_o,
   output logic [XLEN-1:0]           target_o
);

   always_comb begin
      grant_o  = '0;
      target_o = '0;
      // Walk from the lowest priority up so the lowest set index is written last.
      for (int k = NUM_REDIR - 1; k >= 0; k--) begin
         if (redir_valid_i[k]) begin
            grant_o    = '0;
            grant_o[k] = 1'b1;
            target_o   = redir_pc_i[k*XLEN +: XLEN];
         end
      end
`ifdef ROOTH_RVC_EN
      target_o[0] = 1'b0;
`else
      target_o[1:0] = 2'b00;
`endif
   end

   assign any_o = |redir_valid_i;

endmodule

// File: rtl/pc_gen.sv
// Fetch program-counter generator with boot hold and debug halt/resume.
// Build switch: ROOTH_RVC_EN adds inst_len16_i and the +2 sequential step.
//
// state    | meaning
// PCG_BOOT | boot hold after reset/JTAG reset, PC parked at RESET_VEC, no fetch offered
// PCG_RUN  | fetching, PC advances on handshake or is redirected
// PCG_HALT | debug halt, no fetch, debugger may write PC through a redirect
module pc_gen
   import pc_gen_pkg::*;
#(
   parameter int              XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_VEC = '0,
   parameter int              NUM_REDIR = 3,
   parameter int              BOOT_HOLD = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      jtag_reset_flag_i,
   input  logic [FLOW_WIDTH-1:0]     flow_pc_i,
   input  logic [NUM_REDIR-1:0]      redir_valid_i,
   input  logic [NUM_REDIR*XLEN-1:0] redir_pc_i,
`ifdef ROOTH_RVC_EN
   input  logic                      inst_len16_i,
`endif
   input  logic                      halt_req_i,
   input  logic                      resume_req_i,
   input  logic                      pc_ready_i,
   output logic                      pc_valid_o,
   output logic [XLEN-1:0]           curr_pc_o,
   output logic [NUM_REDIR-1:0]      redir_taken_o,
   output logic                      halted_o
);

   localparam int CW = (BOOT_HOLD > 1) ? $clog2(BOOT_HOLD) : 1;
   localparam logic [CW-1:0] BOOT_LOAD = CW'(BOOT_HOLD - 1);

   pcg_state_e           state_q, state_d;
   logic [XLEN-1:0]      pc_q, pc_d;
   logic [NUM_REDIR-1:0] taken_q, taken_d;
   logic [CW-1:0]        boot_cnt_q, boot_cnt_d;

   logic [NUM_REDIR-1:0] redir_grant;
   logic                 redir_any;
   logic [XLEN-1:0]      redir_target;
   logic [XLEN-1:0]      step;

   pc_redir_arb #(
      .XLEN      (XLEN),
      .NUM_REDIR (NUM_REDIR)
   ) u_redir_arb (
      .redir_valid_i (redir_valid_i),
      .redir_pc_i    (redir_pc_i),
      .grant_o       (redir_grant),
      .any_o         (redir_any),
      .target_o      (redir_target)
   );

   always_comb begin
`ifdef ROOTH_RVC_EN
      step = inst_len16_i ? XLEN'(2) : XLEN'(4);
`else
      step = XLEN'(4);
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= PCG_BOOT;
         pc_q       <= RESET_VEC;
         taken_q    <= '0;
         boot_cnt_q <= BOOT_LOAD;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         taken_q    <= taken_d;
         boot_cnt_q <= boot_cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      taken_d    = '0;
      boot_cnt_d = boot_cnt_q;
      case (state_q)
         PCG_BOOT: begin
            if (jtag_reset_flag_i) begin
               pc_d       = RESET_VEC;
               boot_cnt_d = BOOT_LOAD;
            end else if (boot_cnt_q == '0) begin
               state_d = PCG_RUN;
            end else begin
               boot_cnt_d = boot_cnt_q - 1'b1;
            end
         end
         PCG_RUN: begin
            if (jtag_reset_flag_i) begin
               state_d    = PCG_BOOT;
               pc_d       = RESET_VEC;
               boot_cnt_d = BOOT_LOAD;
            end else if (flow_is_refresh(flow_pc_i)) begin
               pc_d = RESET_VEC;
            end else if (redir_any) begin
               pc_d    = redir_target;
               taken_d = redir_grant;
            end else if (flow_pc_i == FLOW_STOP) begin
               pc_d = pc_q;
            end else if (halt_req_i) begin
               state_d = PCG_HALT;
            end else if (pc_ready_i) begin
               pc_d = pc_q + step;
            end
         end
         PCG_HALT: begin
            if (jtag_reset_flag_i) begin
               state_d    = PCG_BOOT;
               pc_d       = RESET_VEC;
               boot_cnt_d = BOOT_LOAD;
            end else begin
               if (redir_any) begin
                  pc_d    = redir_target;
                  taken_d = redir_grant;
               end
               // Resume beats a still-asserted halt request.
               if (resume_req_i) state_d = PCG_RUN;
            end
         end
         default: begin
            state_d    = PCG_BOOT;
            pc_d       = RESET_VEC;
            boot_cnt_d = BOOT_LOAD;
         end
      endcase
   end

   always_comb begin
      pc_valid_o    = (state_q == PCG_RUN);
      halted_o      = (state_q == PCG_HALT);
      curr_pc_o     = pc_q;
      redir_taken_o = taken_q;
   end

endmodule

// File: tb/tb_pc_gen.sv
// Directed plus randomized bench for pc_gen against a cycle-level reference model.
// Default build (ROOTH_RVC_EN undefined): +4 step, redirect targets cleared in bits [1:0].
module tb_pc_gen;
   import pc_gen_pkg::*;

   localparam int XLEN = 32;
   localparam int NR   = 3;
   localparam int BH   = 4;
   localparam logic [31:0] RV = 32'h0;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  jtag_reset_flag_i;
   logic [FLOW_WIDTH-1:0] flow_pc_i;
   logic [NR-1:0]         redir_valid_i;
   logic [NR*XLEN-1:0]    redir_pc_i;
   logic                  inst_len16_i;
   logic                  halt_req_i;
   logic                  resume_req_i;
   logic                  pc_ready_i;
   logic                  pc_valid_o;
   logic [XLEN-1:0]       curr_pc_o;
   logic [NR-1:0]         redir_taken_o;
   logic                  halted_o;

   int n_cmp = 0;
   int n_bad = 0;

   // model: mode 0 boot, 1 run, 2 halt; boot_left = invalid cycles still to come
   int          m_mode;
   int          m_left;
   logic [31:0] m_pc;
   logic [2:0]  m_taken;

   pc_gen #(.XLEN(XLEN), .RESET_VEC(RV), .NUM_REDIR(NR), .BOOT_HOLD(BH)) dut (
      .clk               (clk),
      .rst               (rst),
      .jtag_reset_flag_i (jtag_reset_flag_i),
      .flow_pc_i         (flow_pc_i),
      .redir_valid_i     (redir_valid_i),
      .redir_pc_i        (redir_pc_i),
`ifdef ROOTH_RVC_EN
      .inst_len16_i      (inst_len16_i),
`endif
      .halt_req_i        (halt_req_i),
      .resume_req_i      (resume_req_i),
      .pc_ready_i        (pc_ready_i),
      .pc_valid_o        (pc_valid_o),
      .curr_pc_o         (curr_pc_o),
      .redir_taken_o     (redir_taken_o),
      .halted_o          (halted_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_redirect();
      for (int k = 0; k < NR; k++) begin
         if (redir_valid_i[k]) begin
`ifdef ROOTH_RVC_EN
            m_pc = redir_pc_i[k*XLEN +: XLEN] & 32'hFFFF_FFFE;
`else
            m_pc = redir_pc_i[k*XLEN +: XLEN] & 32'hFFFF_FFFC;
`endif
            m_taken = 3'(1 << k);
            return;
         end
      end
   endtask

   task automatic model_boot_entry();
      m_mode = 0;
      m_left = BH;
      m_pc   = RV;
   endtask

   task automatic model_step();
      logic refresh;
      logic [31:0] inc;
      refresh = (flow_pc_i != 2'd0) && (flow_pc_i != 2'd1);
`ifdef ROOTH_RVC_EN
      inc = inst_len16_i ? 32'd2 : 32'd4;
`else
      inc = 32'd4;
`endif
      m_taken = 3'b000;
      if (rst) begin
         model_boot_entry();
      end else if (m_mode == 0) begin
         if (jtag_reset_flag_i) model_boot_entry();
         else begin
            m_left = m_left - 1;
            if (m_left == 0) m_mode = 1;
         end
      end else if (m_mode == 1) begin
         if (jtag_reset_flag_i) model_boot_entry();
         else if (refresh) m_pc = RV;
         else if (redir_valid_i != 0) model_redirect();
         else if (flow_pc_i == 2'd1) m_pc = m_pc;
         else if (halt_req_i) m_mode = 2;
         else if (pc_ready_i) m_pc = m_pc + inc;
      end else begin
         if (jtag_reset_flag_i) model_boot_entry();
         else begin
            if (redir_valid_i != 0) model_redirect();
            if (resume_req_i) m_mode = 1;
         end
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      check("pc", curr_pc_o, m_pc);
      check("valid", 32'(pc_valid_o), 32'(m_mode == 1));
      check("halted", 32'(halted_o), 32'(m_mode == 2));
      check("taken", 32'(redir_taken_o), 32'(m_taken));
   endtask

   task automatic idle_inputs();
      jtag_reset_flag_i = 1'b0;
      flow_pc_i         = FLOW_WORK;
      redir_valid_i     = '0;
      redir_pc_i        = '0;
      inst_len16_i      = 1'b0;
      halt_req_i        = 1'b0;
      resume_req_i      = 1'b0;
      pc_ready_i        = 1'b0;
   endtask

   task automatic redirect_one(input int ch, input logic [31:0] tgt);
      redir_valid_i = '0;
      redir_valid_i[ch] = 1'b1;
      redir_pc_i[ch*XLEN +: XLEN] = tgt;
   endtask

   initial begin
      idle_inputs();
      rst = 1'b1;
      m_mode = 0; m_left = BH; m_pc = RV; m_taken = '0;
      #2;
      cycle();
      cycle();
      check("rst_pc", curr_pc_o, RV);
      check("rst_valid", 32'(pc_valid_o), 32'd0);

      rst = 1'b0;
      pc_ready_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cycle();
         check("boot_hold", 32'(pc_valid_o), 32'd0);
      end
      cycle();
      check("first_valid", 32'(pc_valid_o), 32'd1);
      check("first_pc", curr_pc_o, 32'h0);
      cycle(); check("seq4", curr_pc_o, 32'h4);
      cycle(); check("seq8", curr_pc_o, 32'h8);
      cycle(); check("seqC", curr_pc_o, 32'hC);
      cycle(); check("seq10", curr_pc_o, 32'h10);

      pc_ready_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cycle();
         check("backpressure", curr_pc_o, 32'h10);
      end
      pc_ready_i = 1'b1;
      flow_pc_i  = FLOW_STOP;
      cycle(); check("flow_stop", curr_pc_o, 32'h10);
      flow_pc_i  = FLOW_WORK;

      pc_ready_i = 1'b0;
      redir_valid_i = 3'b110;
      redir_pc_i[1*XLEN +: XLEN] = 32'h200;
      redir_pc_i[2*XLEN +: XLEN] = 32'h300;
      cycle();
      check("redir_pri_pc", curr_pc_o, 32'h200);
      check("redir_pri_taken", 32'(redir_taken_o), 32'b010);

      redirect_one(0, 32'h203);
      cycle(); check("redir_align", curr_pc_o, 32'h200);

      flow_pc_i = FLOW_REFRESH;
      redirect_one(0, 32'h500);
      cycle();
      check("refresh_pc", curr_pc_o, RV);
      check("refresh_taken", 32'(redir_taken_o), 32'd0);
      idle_inputs();

      pc_ready_i = 1'b1;
      cycle();
      jtag_reset_flag_i = 1'b1;
      cycle();
      check("jtag_pc", curr_pc_o, RV);
      jtag_reset_flag_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cycle();
         check("jtag_hold", 32'(pc_valid_o), 32'd0);
      end
      cycle(); check("jtag_release", 32'(pc_valid_o), 32'd1);

      pc_ready_i = 1'b0;
      redirect_one(2, 32'h40);
      cycle();
      redir_valid_i = '0;
      halt_req_i = 1'b1;
      cycle();
      check("halt_flag", 32'(halted_o), 32'd1);
      check("halt_pc", curr_pc_o, 32'h40);
      halt_req_i = 1'b0;
      flow_pc_i = FLOW_REFRESH;
      cycle(); check("halt_ignores_flow", curr_pc_o, 32'h40);
      flow_pc_i = FLOW_WORK;
      redirect_one(1, 32'h80);
      cycle(); check("halt_redir", curr_pc_o, 32'h80);
      redir_valid_i = '0;
      resume_req_i = 1'b1;
      halt_req_i   = 1'b1;
      cycle(); check("resume_valid", 32'(pc_valid_o), 32'd1);
      resume_req_i = 1'b0;
      halt_req_i   = 1'b0;
      pc_ready_i   = 1'b1;
      cycle(); check("resume_fetch", curr_pc_o, 32'h84);

      pc_ready_i = 1'b0;
      redirect_one(0, 32'hFFFF_FFFC);
      cycle();
      redir_valid_i = '0;
      pc_ready_i = 1'b1;
      cycle(); check("wrap", curr_pc_o, 32'h0);

      for (int i = 0; i < 600; i++) begin
         rst               = ($urandom_range(0, 79) == 0);
         jtag_reset_flag_i = ($urandom_range(0, 39) == 0);
         case ($urandom_range(0, 9))
            0:       flow_pc_i = FLOW_STOP;
            1:       flow_pc_i = FLOW_REFRESH;
            2:       flow_pc_i = 2'd3;
            default: flow_pc_i = FLOW_WORK;
         endcase
         for (int k = 0; k < NR; k++) begin
            redir_valid_i[k] = ($urandom_range(0, 7) == 0);
            redir_pc_i[k*XLEN +: XLEN] = $urandom;
         end
         inst_len16_i = $urandom_range(0, 1) == 1;
         halt_req_i   = ($urandom_range(0, 9) == 0);
         resume_req_i = ($urandom_range(0, 3) == 0);
         pc_ready_i   = $urandom_range(0, 1) == 1;
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
